// File: rtl/mem_access_unit_pkg.sv
// +--------------------------------------------------------------------------+
// | mem_access_unit_pkg : shared codes for the MEM stage (sel, size, FSM).    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package mem_access_unit_pkg;

  localparam logic [3:0] MEM_SEL_BYTE = 4'b0001;
  localparam logic [3:0] MEM_SEL_HALF = 4'b0011;
  localparam logic [3:0] MEM_SEL_WORD = 4'b1111;

  localparam logic [1:0] DATA_SIZE_BYTE = 2'd0;
  localparam logic [1:0] DATA_SIZE_HALF = 2'd1;
  localparam logic [1:0] DATA_SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ADDR = 2'd1,
    ST_WAIT_DATA = 2'd2
  } mem_state_e;

  function automatic logic [1:0] sel_to_size(input logic [3:0] sel);
    case (sel)
      MEM_SEL_BYTE: sel_to_size = DATA_SIZE_BYTE;
      MEM_SEL_HALF: sel_to_size = DATA_SIZE_HALF;
      default:      sel_to_size = DATA_SIZE_WORD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_store_align.sv
// +--------------------------------------------------------------------------+
// | mem_store_align : sel/address/data -> byte strobes, lane data, size.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_store_align
  import mem_access_unit_pkg::*;
(
  input  logic [3:0]  sel,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] store_data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [1:0]  size,
  output logic        misaligned
);

  logic [3:0] w_strb_raw;

  always_comb begin
    w_strb_raw = 4'b1111;
    wdata      = store_data;
    size       = sel_to_size(sel);
    case (sel)
      MEM_SEL_BYTE: begin
        w_strb_raw = 4'b0001 << addr_lo;
        wdata      = {4{store_data[7:0]}};
      end
      MEM_SEL_HALF: begin
        w_strb_raw = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
      end
      default: begin
        w_strb_raw = 4'b1111;
        wdata      = store_data;
      end
    endcase
    // Loads never assert strobes.
    wstrb      = is_store ? w_strb_raw : 4'b0000;
    misaligned = ((sel == MEM_SEL_HALF) && addr_lo[0]) ||
                 ((sel == MEM_SEL_WORD) && (addr_lo != 2'b00));
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// +--------------------------------------------------------------------------+
// | mem_access_unit : MEM stage bus FSM plus MEM/WB pipeline register.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              valid_i,
  input  logic              mem_read_flag_i,
  input  logic              mem_write_flag_i,
  input  logic              mem_sign_ext_flag_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [ADDR_W-1:0] result_i,
  input  logic [DATA_W-1:0] mem_write_data_i,
  input  logic              wb_reg_write_en_i,
  input  logic [4:0]        wb_reg_write_addr_i,
  input  logic [ADDR_W-1:0] current_pc_addr_i,
  input  logic              hilo_write_en_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              stall_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic [DATA_W-1:0] ram_read_data_o,
  output logic              mem_read_flag_o,
  output logic              mem_write_flag_o,
  output logic              mem_sign_ext_flag_o,
  output logic [3:0]        mem_sel_o,
  output logic [ADDR_W-1:0] result_o,
  output logic              wb_reg_write_en_o,
  output logic [4:0]        wb_reg_write_addr_o,
  output logic [ADDR_W-1:0] current_pc_addr_o,
  output logic              hilo_write_en_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  mem_state_e        r_state;
  logic              r_cancel;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_req_wr;
  logic [1:0]        r_req_size;
  logic [3:0]        r_req_wstrb;
  logic [DATA_W-1:0] r_req_wdata;

  logic [3:0]        w_wstrb;
  logic [DATA_W-1:0] w_wdata;
  logic [1:0]        w_size;
  logic              w_misaligned;
  logic              w_is_store;
  logic              w_memop;
  logic              w_idle;
  logic              w_issue;
  logic              w_done;
  logic              w_take;
  logic              w_exc;
  logic              w_pass;

  assign w_is_store = mem_write_flag_i & ~mem_read_flag_i;

  mem_store_align u_align (
    .sel        (mem_sel_i),
    .addr_lo    (result_i[1:0]),
    .is_store   (w_is_store),
    .store_data (mem_write_data_i),
    .wstrb      (w_wstrb),
    .wdata      (w_wdata),
    .size       (w_size),
    .misaligned (w_misaligned)
  );

  assign w_memop = valid_i & (mem_read_flag_i | mem_write_flag_i);
  assign w_idle  = (r_state == ST_IDLE);
  assign w_issue = w_idle & w_memop & ~w_misaligned & ~flush;
  assign w_done  = (r_state == ST_WAIT_DATA) & data_data_ok;
  // Instruction reaches WB: a non-stalling op from IDLE, or a completed, uncancelled access.
  assign w_take  = (w_idle & ~w_issue & valid_i & ~flush) | (w_done & ~r_cancel & ~flush);
  assign w_exc   = w_idle & ~flush & w_memop & w_misaligned;
  assign w_pass  = w_take & ~w_exc;

  // The request is launched from live inputs in IDLE and replayed from the latch afterwards.
  assign data_req   = w_issue | (r_state == ST_WAIT_ADDR);
  assign data_addr  = w_idle ? result_i   : r_req_addr;
  assign data_wr    = w_idle ? w_is_store : r_req_wr;
  assign data_size  = w_idle ? w_size     : r_req_size;
  assign data_wstrb = w_idle ? w_wstrb    : r_req_wstrb;
  assign data_wdata = w_idle ? w_wdata    : r_req_wdata;
  assign stall_o    = w_issue | (r_state == ST_WAIT_ADDR) |
                      ((r_state == ST_WAIT_DATA) & ~data_data_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state             <= ST_IDLE;
      r_cancel            <= 1'b0;
      r_req_addr          <= '0;
      r_req_wr            <= 1'b0;
      r_req_size          <= 2'd0;
      r_req_wstrb         <= 4'd0;
      r_req_wdata         <= '0;
      adel_o              <= 1'b0;
      ades_o              <= 1'b0;
      ram_read_data_o     <= '0;
      mem_read_flag_o     <= 1'b0;
      mem_write_flag_o    <= 1'b0;
      mem_sign_ext_flag_o <= 1'b0;
      mem_sel_o           <= 4'd0;
      result_o            <= '0;
      wb_reg_write_en_o   <= 1'b0;
      wb_reg_write_addr_o <= 5'd0;
      current_pc_addr_o   <= '0;
      hilo_write_en_o     <= 1'b0;
      hi_o                <= '0;
      lo_o                <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_req_addr  <= result_i;
            r_req_wr    <= w_is_store;
            r_req_size  <= w_size;
            r_req_wstrb <= w_wstrb;
            r_req_wdata <= w_wdata;
            r_state     <= data_addr_ok ? ST_WAIT_DATA : ST_WAIT_ADDR;
          end
        end
        ST_WAIT_ADDR: begin
          if (flush)        r_cancel <= 1'b1;
          if (data_addr_ok) r_state  <= ST_WAIT_DATA;
        end
        ST_WAIT_DATA: begin
          if (data_data_ok) begin
            r_state  <= ST_IDLE;
            r_cancel <= 1'b0;
          end else if (flush) begin
            r_cancel <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // MEM/WB: bubble while stalled or squashed, so WB never repeats a write.
      adel_o              <= w_exc & mem_read_flag_i;
      ades_o              <= w_exc & ~mem_read_flag_i;
      ram_read_data_o     <= (w_pass & w_done & mem_read_flag_i) ? data_rdata : '0;
      mem_read_flag_o     <= w_pass & mem_read_flag_i;
      mem_write_flag_o    <= w_pass & mem_write_flag_i;
      mem_sign_ext_flag_o <= w_pass & mem_sign_ext_flag_i;
      mem_sel_o           <= w_pass ? mem_sel_i : 4'd0;
      result_o            <= (w_take & ~(w_pass & w_is_store)) ? result_i : '0;
      wb_reg_write_en_o   <= w_pass & wb_reg_write_en_i;
      wb_reg_write_addr_o <= w_take ? wb_reg_write_addr_i : 5'd0;
      current_pc_addr_o   <= w_take ? current_pc_addr_i : '0;
      hilo_write_en_o     <= w_pass & hilo_write_en_i;
      hi_o                <= w_pass ? hi_i : '0;
      lo_o                <= w_pass ? lo_i : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// +--------------------------------------------------------------------------+
// | tb_mem_access_unit : directed self-checking bench for mem_access_unit.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        valid_i;
  logic        mem_read_flag_i, mem_write_flag_i, mem_sign_ext_flag_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] result_i, mem_write_data_i;
  logic        wb_reg_write_en_i;
  logic [4:0]  wb_reg_write_addr_i;
  logic [31:0] current_pc_addr_i;
  logic        hilo_write_en_i;
  logic [31:0] hi_i, lo_i;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        stall_o, adel_o, ades_o;
  logic [31:0] ram_read_data_o;
  logic        mem_read_flag_o, mem_write_flag_o, mem_sign_ext_flag_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] result_o;
  logic        wb_reg_write_en_o;
  logic [4:0]  wb_reg_write_addr_o;
  logic [31:0] current_pc_addr_o;
  logic        hilo_write_en_o;
  logic [31:0] hi_o, lo_o;

  int n_cmp = 0;
  int n_err = 0;
  int stall_cnt;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_i(valid_i),
    .mem_read_flag_i(mem_read_flag_i), .mem_write_flag_i(mem_write_flag_i),
    .mem_sign_ext_flag_i(mem_sign_ext_flag_i), .mem_sel_i(mem_sel_i),
    .result_i(result_i), .mem_write_data_i(mem_write_data_i),
    .wb_reg_write_en_i(wb_reg_write_en_i), .wb_reg_write_addr_i(wb_reg_write_addr_i),
    .current_pc_addr_i(current_pc_addr_i), .hilo_write_en_i(hilo_write_en_i),
    .hi_i(hi_i), .lo_i(lo_i),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .stall_o(stall_o), .adel_o(adel_o), .ades_o(ades_o),
    .ram_read_data_o(ram_read_data_o),
    .mem_read_flag_o(mem_read_flag_o), .mem_write_flag_o(mem_write_flag_o),
    .mem_sign_ext_flag_o(mem_sign_ext_flag_o), .mem_sel_o(mem_sel_o),
    .result_o(result_o), .wb_reg_write_en_o(wb_reg_write_en_o),
    .wb_reg_write_addr_o(wb_reg_write_addr_o), .current_pc_addr_o(current_pc_addr_o),
    .hilo_write_en_o(hilo_write_en_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; valid_i = 0;
    mem_read_flag_i = 0; mem_write_flag_i = 0; mem_sign_ext_flag_i = 0;
    mem_sel_i = 4'b0000; result_i = 0; mem_write_data_i = 0;
    wb_reg_write_en_i = 0; wb_reg_write_addr_i = 0; current_pc_addr_i = 0;
    hilo_write_en_i = 0; hi_i = 0; lo_i = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
  endtask

  task automatic set_mem(input logic rd, input logic wr, input logic [3:0] sel,
                         input logic [31:0] addr, input logic [31:0] wd);
    valid_i = 1; mem_read_flag_i = rd; mem_write_flag_i = wr; mem_sel_i = sel;
    result_i = addr; mem_write_data_i = wd;
    wb_reg_write_en_i = rd; wb_reg_write_addr_i = 5'd8;
    current_pc_addr_i = 32'hBFC0_0100;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    step(); step();
    check("rst_req", {31'd0, data_req}, 0);
    check("rst_stall", {31'd0, stall_o}, 0);
    check("rst_result", result_o, 0);
    check("rst_wben", {31'd0, wb_reg_write_en_o}, 0);
    rst = 0;

    // ALU op
    valid_i = 1; result_i = 32'h1234; wb_reg_write_en_i = 1; wb_reg_write_addr_i = 5;
    current_pc_addr_i = 32'hBFC0_0000; hilo_write_en_i = 1; hi_i = 32'h11; lo_i = 32'h22;
    #1;
    check("alu_stall", {31'd0, stall_o}, 0);
    check("alu_req", {31'd0, data_req}, 0);
    step();
    check("alu_result", result_o, 32'h1234);
    check("alu_wben", {31'd0, wb_reg_write_en_o}, 1);
    check("alu_waddr", {27'd0, wb_reg_write_addr_o}, 5);
    check("alu_pc", current_pc_addr_o, 32'hBFC0_0000);
    check("alu_hilo", {31'd0, hilo_write_en_o}, 1);
    check("alu_lo", lo_o, 32'h22);
    clear_inputs();

    // lw 0x80000010: addr_ok after 2 cycles, data_ok 3 cycles later
    stall_cnt = 0;
    set_mem(1, 0, 4'b1111, 32'h8000_0010, 0);
    #1;
    check("lw_req0", {31'd0, data_req}, 1);
    check("lw_addr", data_addr, 32'h8000_0010);
    check("lw_size", {30'd0, data_size}, 2);
    check("lw_wstrb", {28'd0, data_wstrb}, 0);
    check("lw_wr", {31'd0, data_wr}, 0);
    stall_cnt += int'(stall_o);
    step();
    check("lw_req1", {31'd0, data_req}, 1);
    check("lw_bubble", {31'd0, wb_reg_write_en_o}, 0);
    stall_cnt += int'(stall_o);
    step();
    data_addr_ok = 1; #1;
    check("lw_addr_hold", data_addr, 32'h8000_0010);
    stall_cnt += int'(stall_o);
    step();
    data_addr_ok = 0; #1;
    check("lw_req_waitdata", {31'd0, data_req}, 0);
    stall_cnt += int'(stall_o);
    step();
    stall_cnt += int'(stall_o);
    step();
    data_data_ok = 1; data_rdata = 32'hDEAD_BEEF; #1;
    check("lw_stall_release", {31'd0, stall_o}, 0);
    stall_cnt += int'(stall_o);
    step();
    check("lw_stall_cycles", stall_cnt, 5);
    check("lw_rdata", ram_read_data_o, 32'hDEAD_BEEF);
    check("lw_result", result_o, 32'h8000_0010);
    check("lw_rdflag", {31'd0, mem_read_flag_o}, 1);
    check("lw_wben", {31'd0, wb_reg_write_en_o}, 1);
    clear_inputs();

    // sb 0xAB to 0x103, address accepted at once
    set_mem(0, 1, 4'b0001, 32'h0000_0103, 32'h1234_56AB);
    data_addr_ok = 1; #1;
    check("sb_wr", {31'd0, data_wr}, 1);
    check("sb_size", {30'd0, data_size}, 0);
    check("sb_wstrb", {28'd0, data_wstrb}, 4'b1000);
    check("sb_wdata", data_wdata, 32'hABAB_ABAB);
    step();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h5555_5555; #1;
    check("sb_stall", {31'd0, stall_o}, 0);
    step();
    check("sb_result", result_o, 0);
    check("sb_ram", ram_read_data_o, 0);
    check("sb_wrflag", {31'd0, mem_write_flag_o}, 1);
    clear_inputs();

    // sh to 0x102
    set_mem(0, 1, 4'b0011, 32'h0000_0102, 32'h0000_BEEF);
    data_addr_ok = 1; #1;
    check("sh_wstrb", {28'd0, data_wstrb}, 4'b1100);
    check("sh_wdata", data_wdata, 32'hBEEF_BEEF);
    check("sh_size", {30'd0, data_size}, 1);
    step();
    data_addr_ok = 0; data_data_ok = 1; #1;
    step();
    clear_inputs();

    // lh at 0x101: misaligned load
    set_mem(1, 0, 4'b0011, 32'h0000_0101, 0);
    #1;
    check("lh_noreq", {31'd0, data_req}, 0);
    check("lh_nostall", {31'd0, stall_o}, 0);
    step();
    clear_inputs();
    check("lh_adel", {31'd0, adel_o}, 1);
    check("lh_ades", {31'd0, ades_o}, 0);
    check("lh_wben", {31'd0, wb_reg_write_en_o}, 0);
    step();
    check("lh_adel_pulse", {31'd0, adel_o}, 0);

    // sw at 0x102: misaligned store
    set_mem(0, 1, 4'b1111, 32'h0000_0102, 32'h1);
    #1;
    check("sw_noreq", {31'd0, data_req}, 0);
    step();
    clear_inputs();
    check("sw_ades", {31'd0, ades_o}, 1);
    check("sw_adel", {31'd0, adel_o}, 0);

    // lw with flush in WAIT_DATA
    set_mem(1, 0, 4'b1111, 32'h0000_0200, 0);
    data_addr_ok = 1; #1;
    step();
    data_addr_ok = 0; flush = 1; #1;
    check("fl_stall_held", {31'd0, stall_o}, 1);
    step();
    flush = 0; data_data_ok = 1; data_rdata = 32'h1111_2222; #1;
    check("fl_stall_release", {31'd0, stall_o}, 0);
    step();
    check("fl_wben", {31'd0, wb_reg_write_en_o}, 0);
    check("fl_rdflag", {31'd0, mem_read_flag_o}, 0);
    clear_inputs(); #1;
    check("fl_idle", {31'd0, data_req}, 0);

    // rst in WAIT_ADDR
    set_mem(1, 0, 4'b1111, 32'h0000_0300, 0);
    step();
    check("rs_waitaddr_req", {31'd0, data_req}, 1);
    rst = 1; valid_i = 0;
    step();
    check("rs_req", {31'd0, data_req}, 0);
    check("rs_stall", {31'd0, stall_o}, 0);
    check("rs_result", result_o, 0);
    check("rs_pc", current_pc_addr_o, 0);
    rst = 0;
    clear_inputs();
    data_data_ok = 1; #1;
    check("idle_dataok_ignored", {31'd0, stall_o}, 0);
    step();
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM stage plus MEM/WB pipeline register of the 5-stage MIPS core; feeds WB directly.
- Issues load/store transactions on an SRAM-like data bus and stalls the pipeline until the data phase completes.
- Forwards the raw aligned word to WB. WB performs byte/half extraction and sign extension from mem_sel, address[1:0] and the sign-extend flag.

Parameters:
ADDR_W, 32, address width (`ADDR_BUS`)
DATA_W, 32, data width (`DATA_BUS`)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  squash the instruction currently in MEM
valid_i  in  1  an instruction occupies MEM this cycle
mem_read_flag_i / mem_write_flag_i / mem_sign_ext_flag_i  in  1 each  load, store, signed-load
mem_sel_i  in  4  0001 byte, 0011 half, 1111 word
result_i  in  32  ALU result; the effective address for memory ops
mem_write_data_i  in  32  store source (rt)
wb_reg_write_en_i / wb_reg_write_addr_i  in  1/5  regfile write
current_pc_addr_i  in  32  PC
hilo_write_en_i / hi_i / lo_i  in  1/32/32  HI/LO write
data_req / data_wr  out  1/1  bus request; 1 = write
data_size  out  2  0 byte, 1 half, 2 word
data_addr  out  32  {result_i[31:2], result_i[1:0]}
data_wstrb  out  4  byte strobes
data_wdata  out  32  replicated store data
data_addr_ok / data_data_ok  in  1/1  address accepted / data phase done
data_rdata  in  32  read word
stall_o  out  1  hold IF..MEM
adel_o / ades_o  out  1/1  registered load/store address-error pulse
ram_read_data_o  out  32  registered read word, to WB
mem_read_flag_o, mem_write_flag_o, mem_sign_ext_flag_o, mem_sel_o, result_o, wb_reg_write_en_o, wb_reg_write_addr_o, current_pc_addr_o, hilo_write_en_o, hi_o, lo_o  out  —  registered copies to WB

Behaviour:
Reset:
- Every registered output is 0. FSM enters IDLE and the cancel flag clears.
- data_req and stall_o are 0.

Definitions:
- memop = valid_i & (mem_read_flag_i | mem_write_flag_i).
- misaligned = (sel==0011 & addr[0]) | (sel==1111 & addr[1:0]!=0).

Non-memory instruction, or flush in IDLE:
- MEM/WB loads in 1 cycle.
- On flush, or when !valid_i, a bubble is loaded: all enables/flags 0.

Misaligned memop:
- No bus request.
- Next cycle: adel_o (load) or ades_o (store) = 1 for one cycle, and wb_reg_write_en_o = hilo_write_en_o = 0.

FSM states: IDLE, WAIT_ADDR, WAIT_DATA.
- IDLE, aligned memop, no flush:
  - data_req = 1 combinationally.
  - data_addr_ok -> WAIT_DATA, else -> WAIT_ADDR.
  - stall_o = 1.
- WAIT_ADDR:
  - data_req, data_addr, data_wr, data_size, data_wstrb, data_wdata held stable; upstream is frozen by stall_o.
  - data_addr_ok -> WAIT_DATA.
  - stall_o = 1.
- WAIT_DATA:
  - data_req = 0; stall_o = 1 until data_data_ok.
  - On data_data_ok: stall_o = 0 in the same cycle; MEM/WB loads, with ram_read_data_o <= data_rdata for loads and 0 for stores; -> IDLE.
- data_data_ok is never expected in IDLE and is ignored there. data_data_ok is never expected in the same cycle as data_addr_ok.

Store encoding:
- Byte: wstrb = 0001 << addr[1:0], wdata = {4{wd[7:0]}}, size 0.
- Half: wstrb = addr[1] ? 1100 : 0011, wdata = {2{wd[15:0]}}, size 1.
- Word: wstrb = 1111, wdata = wd, size 2.

Loads:
- wstrb = 0000; size from sel, same mapping as stores.

Flush during WAIT_ADDR or WAIT_DATA:
- The bus transaction cannot be withdrawn, so it completes normally on the bus.
- The cancel flag sets; on data_data_ok a bubble is loaded instead of the instruction and the flag clears.
- flush never deasserts stall_o early.

rst mid-transaction:
- Returns to IDLE immediately. The external bus is reset by the same rst.

result_o:
- result_i for loads, so WB has addr[1:0]; 0 for stores; result_i otherwise.

Decomposition:
- Shared include (bus.v/opcode.v): MEM_SEL_* codes, DATA_SIZE_* codes, FSM state encodings.
- One natural sub-module, mem_store_align: combinational sel/address/data -> wstrb, wdata, size, misaligned.
- FSM and the MEM/WB register stay in the top module.

Test Plan:
- ALU op, result_i=0x1234, reg write to $5 -> next cycle result_o=0x1234, wb_reg_write_en_o=1, wb_reg_write_addr_o=5, stall_o never asserted.
- lw at 0x80000010, addr_ok after 2 cycles, data_ok 3 cycles later with rdata 0xDEADBEEF -> stall_o high for 5 cycles; then ram_read_data_o=0xDEADBEEF, result_o=0x80000010.
- sb 0xAB to 0x103 -> data_wr=1, size=0, wstrb=1000, wdata=0xABABABAB; sh to 0x102 -> wstrb=1100, wdata={2{hw}}.
- lh at 0x101 -> no data_req; next cycle adel_o=1, wb_reg_write_en_o=0. sw at 0x102 -> ades_o=1.
- lw with flush asserted in WAIT_DATA -> bus completes; after data_ok, wb_reg_write_en_o=0, mem_read_flag_o=0.
- rst asserted in WAIT_ADDR -> next cycle state IDLE, data_req=0, stall_o=0, all outputs 0.
